// File: rtl/rvne_mem_pkg.sv
// Shared types and sizing for the MEM stage of the RV32 + vector pipeline.
// Holds the access FSM state enum, bus/buffer widths and the beat-count helper.
package rvne_mem_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MAX_BEATS = 8;
  localparam int unsigned BEAT_W    = $clog2(MAX_BEATS + 1);
  localparam int unsigned SLOT_W    = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Words moved by one access: vector loads fetch 2^VL words, everything else one.
  function automatic logic [BEAT_W-1:0] beat_count(input logic [1:0] vl, input logic is_vload);
    logic [BEAT_W-1:0] n;
    n = is_vload ? (BEAT_W'(1) << vl) : BEAT_W'(1);
    return n;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
// Signals: dmem_req/dmem_we/dmem_addr/dmem_wdata (master -> slave),
//          dmem_ready/dmem_rvalid/dmem_rdata (slave -> master).
// A request is accepted on a cycle with dmem_req & dmem_ready; read data
// returns in order on dmem_rvalid, one request outstanding at a time.
interface mem_access_stage_if;
  import rvne_mem_pkg::*;

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ready;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_load_buffer.sv
// MAX_BEATS x XLEN assembler for multi-beat loads.
// Ports: clk, reset (async, active-high), clear (zero all slots),
//        we + slot + wdata (write one word), data (flat view, word k at [32k+31:32k]).
module mem_load_buffer
  import rvne_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      we,
  input  logic [SLOT_W-1:0]         slot,
  input  logic [XLEN-1:0]           wdata,
  output logic [MAX_BEATS*XLEN-1:0] data
);

  logic [XLEN-1:0] word_q [MAX_BEATS];

  // Clear has priority so a new load never sees words of the previous one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_BEATS; i++) word_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < MAX_BEATS; i++) word_q[i] <= '0;
    end else if (we) begin
      word_q[slot] <= wdata;
    end
  end

  // Flatten for the WB bundle.
  always_comb begin
    data = '0;
    for (int i = 0; i < MAX_BEATS; i++) data[i*XLEN +: XLEN] = word_q[i];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the data-memory bus for EX/MEM loads/stores, sequences
// multi-beat vector loads, resolves branches and registers the WB bundle.
// Ports: clk, reset (async, active-high); EX/MEM inputs (adder_in, zero_in,
//        alu_result_in, writedata_in, rd_in, controls, VL_in); pcsrc and
//        branch_target (combinational); stall (combinational hold of
//        upstream); bus (mem_access_stage_if.master); wb_* bundle and misalign.
// Build option: MEM_MISALIGN_CHECK_EN - when defined, a mem op whose address
//        has non-zero low bits skips the bus and retires with misalign = 1 and
//        register writes suppressed; otherwise the address is word-aligned.
module mem_access_stage
  import rvne_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [XLEN-1:0]           adder_in,
  input  logic                      zero_in,
  input  logic [XLEN-1:0]           alu_result_in,
  input  logic [XLEN-1:0]           writedata_in,
  input  logic [4:0]                rd_in,
  input  logic                      branch_in,
  input  logic                      memtoreg_in,
  input  logic                      memwrite_in,
  input  logic                      regwrite_in,
  input  logic                      WVRwrite_in,
  input  logic                      SVRwrite_in,
  input  logic [1:0]                VL_in,
  output logic                      pcsrc,
  output logic [XLEN-1:0]           branch_target,
  output logic                      stall,
  mem_access_stage_if.master        bus,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic                      wb_regwrite,
  output logic                      wb_memtoreg,
  output logic                      wb_WVRwrite,
  output logic                      wb_SVRwrite,
  output logic [XLEN-1:0]           wb_alu_result,
  output logic [MAX_BEATS*XLEN-1:0] wb_load_data,
  output logic                      misalign
);

  mem_state_e       state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc, n_beats;
  logic             req_d, we_d;
  logic [XLEN-1:0]  addr_d, wdata_d, addr_first, addr_next;
  logic             mem_op, any_ctrl, misaligned;
  logic             buf_clear, buf_we, wb_capture, wb_valid_d, misalign_d;

  assign pcsrc         = branch_in & zero_in;
  assign branch_target = adder_in;
  assign mem_op        = memtoreg_in | memwrite_in;
  assign any_ctrl      = branch_in | memtoreg_in | memwrite_in | regwrite_in | WVRwrite_in | SVRwrite_in;
  assign stall         = (state_q != DONE) & ((state_q != IDLE) | mem_op);
  assign n_beats       = beat_count(VL_in, memtoreg_in & WVRwrite_in);
  assign beat_inc      = beat_q + BEAT_W'(1);

  // Word addresses; the 30-bit add wraps exactly like base + 4*beat mod 2^32.
  assign addr_first = {alu_result_in[XLEN-1:2], 2'b00};
  assign addr_next  = {alu_result_in[XLEN-1:2] + (XLEN-2)'(beat_inc), 2'b00};

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = mem_op & (alu_result_in[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Next-state and next bus/WB values.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    req_d      = bus.dmem_req;
    we_d       = bus.dmem_we;
    addr_d     = bus.dmem_addr;
    wdata_d    = bus.dmem_wdata;
    buf_clear  = 1'b0;
    buf_we     = 1'b0;
    wb_capture = 1'b0;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op) begin
          beat_d    = '0;
          buf_clear = memtoreg_in;
          if (misaligned) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = memwrite_in;
            addr_d  = addr_first;
            wdata_d = writedata_in;
          end
        end else begin
          // Single-cycle op or bubble retires straight from IDLE.
          wb_capture = 1'b1;
          wb_valid_d = any_ctrl;
        end
      end
      REQ: begin
        if (bus.dmem_ready) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = memwrite_in ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid) begin
          buf_we = 1'b1;
          beat_d = beat_inc;
          if (beat_inc < n_beats) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = addr_next;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        wb_capture = 1'b1;
        wb_valid_d = 1'b1;
        misalign_d = misaligned;
        beat_d     = '0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, bus and WB registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_regwrite    <= 1'b0;
      wb_memtoreg    <= 1'b0;
      wb_WVRwrite    <= 1'b0;
      wb_SVRwrite    <= 1'b0;
      wb_alu_result  <= '0;
      misalign       <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      bus.dmem_req   <= req_d;
      bus.dmem_we    <= we_d;
      bus.dmem_addr  <= addr_d;
      bus.dmem_wdata <= wdata_d;
      wb_valid       <= wb_valid_d;
      misalign       <= misalign_d;
      if (wb_capture) begin
        wb_rd         <= rd_in;
        wb_regwrite   <= regwrite_in & ~misaligned;
        wb_memtoreg   <= memtoreg_in;
        wb_WVRwrite   <= WVRwrite_in & ~misaligned;
        wb_SVRwrite   <= SVRwrite_in & ~misaligned;
        wb_alu_result <= alu_result_in;
      end
    end
  end

  mem_load_buffer u_load_buffer (
    .clk   (clk),
    .reset (reset),
    .clear (buf_clear),
    .we    (buf_we),
    .slot  (SLOT_W'(beat_q)),
    .wdata (bus.dmem_rdata),
    .data  (wb_load_data)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected bus beats and
// WB bundles; a memory model and a WB monitor pop and compare independently.
`timescale 1ns/1ps
module tb_mem_access_stage;
  import rvne_mem_pkg::*;

  localparam int unsigned LDW = MAX_BEATS * XLEN;

  typedef struct {
    logic [31:0] adder, alu, wdata;
    logic        zero, branch, memtoreg, memwrite, regwrite, wvr, svr;
    logic [4:0]  rd;
    logic [1:0]  vl;
  } instr_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [4:0]     rd;
    logic           regwrite, memtoreg, wvr, svr, mis, chk_data;
    logic [31:0]    alu;
    logic [LDW-1:0] data;
  } wb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] adder_in = '0, alu_result_in = '0, writedata_in = '0;
  logic zero_in = 0, branch_in = 0, memtoreg_in = 0, memwrite_in = 0;
  logic regwrite_in = 0, WVRwrite_in = 0, SVRwrite_in = 0;
  logic [4:0] rd_in = '0;
  logic [1:0] VL_in = '0;
  logic pcsrc, stall, wb_valid, wb_regwrite, wb_memtoreg, wb_WVRwrite, wb_SVRwrite, misalign;
  logic [31:0] branch_target, wb_alu_result;
  logic [4:0] wb_rd;
  logic [LDW-1:0] wb_load_data;

  mem_access_stage_if bus();

  mem_access_stage dut (
    .clk(clk), .reset(reset), .adder_in(adder_in), .zero_in(zero_in),
    .alu_result_in(alu_result_in), .writedata_in(writedata_in), .rd_in(rd_in),
    .branch_in(branch_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
    .regwrite_in(regwrite_in), .WVRwrite_in(WVRwrite_in), .SVRwrite_in(SVRwrite_in),
    .VL_in(VL_in), .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
    .bus(bus), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_memtoreg(wb_memtoreg), .wb_WVRwrite(wb_WVRwrite), .wb_SVRwrite(wb_SVRwrite),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bus_t exp_bus[$];
  wb_t  exp_wb[$];

  // Memory-model controls
  int unsigned ready_block = 0;
  bit ready_force = 0;
  bit hold_resp = 0;
  bit abort_mode = 0;
  int unsigned accepted_cnt = 0;
  bit pend = 0;
  int unsigned pend_dly = 0;
  logic [31:0] pend_data = '0;

  task automatic chk(input string name, input logic [LDW-1:0] act, input logic [LDW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'hC0FFEE11;
  endfunction

  function automatic instr_t blank();
    instr_t r;
    r.adder = '0; r.alu = '0; r.wdata = '0; r.zero = 0; r.branch = 0; r.memtoreg = 0;
    r.memwrite = 0; r.regwrite = 0; r.wvr = 0; r.svr = 0; r.rd = '0; r.vl = '0;
    return r;
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r = blank();
    r.adder = $urandom; r.wdata = $urandom; r.alu = $urandom;
    r.zero = 1'($urandom_range(0, 1));
    r.rd = 5'($urandom); r.vl = 2'($urandom);
    if ($urandom_range(0, 3) == 0) r.alu = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
    if ($urandom_range(0, 3) != 0) r.alu[1:0] = 2'b00;
    case ($urandom_range(0, 6))
      0: ;
      1: begin r.regwrite = 1; r.svr = 1'($urandom_range(0, 1)); end
      2: r.branch = 1;
      3: begin r.memtoreg = 1; r.regwrite = 1; end
      4: begin r.memtoreg = 1; r.wvr = 1; end
      5: r.memwrite = 1;
      default: r.wvr = 1;
    endcase
    return r;
  endfunction

  task automatic drive(input instr_t in);
    adder_in = in.adder; zero_in = in.zero; alu_result_in = in.alu; writedata_in = in.wdata;
    rd_in = in.rd; branch_in = in.branch; memtoreg_in = in.memtoreg; memwrite_in = in.memwrite;
    regwrite_in = in.regwrite; WVRwrite_in = in.wvr; SVRwrite_in = in.svr; VL_in = in.vl;
  endtask

  // Present one instruction, queue its expected bus beats and WB bundle, and hold it until the stage releases stall.
  task automatic issue(input instr_t in, input int unsigned blk, output int stall_cycles);
    bit mem_op, mis, any;
    int beats, guard;
    logic [31:0] a;
    wb_t w;
    @(negedge clk); #2;
    drive(in);
    if (blk != 0) ready_block = blk;
    mem_op = in.memtoreg | in.memwrite;
    any = in.branch | mem_op | in.regwrite | in.wvr | in.svr;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = mem_op && (in.alu[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    beats = (in.memtoreg && in.wvr) ? (1 << in.vl) : 1;
    w.rd = in.rd; w.regwrite = in.regwrite & ~mis; w.memtoreg = in.memtoreg;
    w.wvr = in.wvr & ~mis; w.svr = in.svr & ~mis; w.mis = mis; w.alu = in.alu;
    w.chk_data = in.memtoreg & ~in.memwrite & ~mis;
    w.data = '0;
    for (int k = 0; k < beats; k++) begin
      a = (in.alu & 32'hFFFF_FFFC) + 32'(4 * k);
      if (mem_op && !mis) exp_bus.push_back('{addr: a, we: in.memwrite, wdata: in.wdata});
      w.data[k*32 +: 32] = mem_word(a);
    end
    if (any) exp_wb.push_back(w);
    #1;
    chk("pcsrc", LDW'(pcsrc), LDW'(in.branch & in.zero));
    chk("branch_target", LDW'(branch_target), LDW'(in.adder));
    chk("stall_at_issue", LDW'(stall), LDW'(mem_op));
    stall_cycles = 0;
    guard = 0;
    while (stall === 1'b1 && guard < 300) begin
      stall_cycles++;
      @(negedge clk); #3;
      guard++;
    end
    if (guard >= 300) chk("stall_timeout", LDW'(1), LDW'(0));
    if (mem_op) chk("beats_done_at_release", LDW'(exp_bus.size()), LDW'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wb_valid"}, LDW'(wb_valid), '0);
    chk({tag, "_wb_rd"}, LDW'(wb_rd), '0);
    chk({tag, "_wb_ctrl"}, LDW'({wb_regwrite, wb_memtoreg, wb_WVRwrite, wb_SVRwrite}), '0);
    chk({tag, "_wb_alu_result"}, LDW'(wb_alu_result), '0);
    chk({tag, "_wb_load_data"}, wb_load_data, '0);
    chk({tag, "_misalign"}, LDW'(misalign), '0);
    chk({tag, "_dmem_req_we"}, LDW'({bus.dmem_req, bus.dmem_we}), '0);
    chk({tag, "_dmem_addr"}, LDW'(bus.dmem_addr), '0);
    chk({tag, "_dmem_wdata"}, LDW'(bus.dmem_wdata), '0);
    chk({tag, "_stall"}, LDW'(stall), '0);
    chk({tag, "_pcsrc"}, LDW'(pcsrc), '0);
  endtask

  // Memory model: random ready, in-order read data 1..3 cycles after accept, stray rvalid when idle.
  always @(negedge clk) begin
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata = $urandom;
    if (!hold_resp) begin
      if (pend) begin
        if (pend_dly == 0) begin
          bus.dmem_rvalid = 1'b1;
          bus.dmem_rdata = pend_data;
          pend = 0;
        end else pend_dly--;
      end else if ($urandom_range(0, 7) == 0) bus.dmem_rvalid = 1'b1;
    end
    if (ready_block != 0) begin
      bus.dmem_ready = 1'b0;
      ready_block--;
      if (ready_block == 0) ready_force = 1;
    end else if (ready_force) begin
      bus.dmem_ready = 1'b1;
      ready_force = 0;
    end else bus.dmem_ready = ($urandom_range(0, 2) != 0);
    if (!reset && bus.dmem_req === 1'b1 && !abort_mode) begin
      if (exp_bus.size() == 0) chk("unexpected_dmem_req", LDW'(bus.dmem_addr), LDW'(32'hFFFF_FFFF));
      else begin
        chk("dmem_addr", LDW'(bus.dmem_addr), LDW'(exp_bus[0].addr));
        chk("dmem_we", LDW'(bus.dmem_we), LDW'(exp_bus[0].we));
        if (exp_bus[0].we) chk("dmem_wdata", LDW'(bus.dmem_wdata), LDW'(exp_bus[0].wdata));
      end
    end
    if (!reset && bus.dmem_req === 1'b1 && bus.dmem_ready) begin
      accepted_cnt++;
      if (!abort_mode && exp_bus.size() != 0) void'(exp_bus.pop_front());
      if (bus.dmem_we !== 1'b1) begin
        pend = 1;
        pend_dly = $urandom_range(0, 2);
        pend_data = mem_word(bus.dmem_addr);
      end
    end
  end

  // WB monitor: every wb_valid pops one expected bundle.
  always @(negedge clk) begin
    wb_t e;
    if (!reset) begin
      if (wb_valid === 1'b1) begin
        if (exp_wb.size() == 0) chk("unexpected_wb_valid", LDW'(wb_rd), LDW'(6'h3F));
        else begin
          e = exp_wb.pop_front();
          chk("wb_rd", LDW'(wb_rd), LDW'(e.rd));
          chk("wb_ctrl", LDW'({wb_regwrite, wb_memtoreg, wb_WVRwrite, wb_SVRwrite}),
              LDW'({e.regwrite, e.memtoreg, e.wvr, e.svr}));
          chk("wb_alu_result", LDW'(wb_alu_result), LDW'(e.alu));
          chk("wb_misalign", LDW'(misalign), LDW'(e.mis));
          if (e.chk_data) chk("wb_load_data", wb_load_data, e.data);
        end
      end else chk("misalign_without_valid", LDW'(misalign), '0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Abort a 4-beat load while it waits for data; the late response must be dropped.
  task automatic reset_mid_access();
    instr_t in;
    int unsigned start;
    int guard;
    abort_mode = 1; hold_resp = 1;
    in = blank(); in.memtoreg = 1; in.wvr = 1; in.vl = 2'd2; in.alu = 32'h300; in.rd = 5'd3;
    @(negedge clk); #2;
    drive(in);
    start = accepted_cnt;
    guard = 0;
    while (accepted_cnt == start && guard < 50) begin @(negedge clk); #3; guard++; end
    chk("t5_first_beat_accepted", LDW'(accepted_cnt - start), LDW'(1));
    @(negedge clk); #2;
    reset = 1'b1;
    drive(blank());
    #1;
    check_reset_outputs("t5_reset");
    @(negedge clk); #2;
    reset = 1'b0; hold_resp = 0; abort_mode = 0;
    repeat (5) @(negedge clk);
    chk("t5_no_wb_after_abort", LDW'(exp_wb.size()), '0);
  endtask

  initial begin
    instr_t in;
    int sc, g;
    drive(blank());
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    #1 reset = 1'b0;

    // ALU op retires in one cycle without touching the bus
    in = blank(); in.regwrite = 1; in.rd = 5'd5; in.alu = 32'h1234;
    issue(in, 0, sc);
    chk("t1_stall_cycles", LDW'(sc), '0);

    // Branch taken / not taken
    in = blank(); in.branch = 1; in.zero = 1; in.adder = 32'h40;
    issue(in, 0, sc);
    in.zero = 0;
    issue(in, 0, sc);

    // Store with ready refused for 3 REQ cycles: IDLE + 3 refused + 1 accepted
    in = blank(); in.memwrite = 1; in.alu = 32'h100; in.wdata = 32'hDEADBEEF;
    issue(in, 3, sc);
    chk("t2_stall_cycles", LDW'(sc), LDW'(5));

    // 4-beat vector load, upper slots zero
    in = blank(); in.memtoreg = 1; in.wvr = 1; in.vl = 2'd2; in.alu = 32'h200; in.rd = 5'd9;
    issue(in, 0, sc);

    // 8-beat vector load wrapping past the top of the address space
    in = blank(); in.memtoreg = 1; in.wvr = 1; in.vl = 2'd3; in.alu = 32'hFFFF_FFF4; in.rd = 5'd7;
    issue(in, 0, sc);

    // Load at an unaligned address
    in = blank(); in.memtoreg = 1; in.regwrite = 1; in.alu = 32'h102; in.rd = 5'd4;
    issue(in, 0, sc);

    reset_mid_access();

    // Scalar load after the aborted access
    in = blank(); in.memtoreg = 1; in.regwrite = 1; in.alu = 32'h500; in.rd = 5'd12;
    issue(in, 0, sc);

    for (int i = 0; i < 300; i++) begin
      in = rand_instr();
      issue(in, 0, sc);
    end

    g = 0;
    while (exp_wb.size() != 0 && g < 50) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    chk("drain_wb", LDW'(exp_wb.size()), '0);
    chk("drain_bus", LDW'(exp_bus.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
